mc_control_fsm: RTL

Multi-cycle main controller for the MIPS-lite core, the sequential successor to the single-cycle opcode decoder. It decodes the 6-bit opcode and sequences fetch/decode/execute/memory/writeback over several cycles, driving datapath enables and mux selects. It handshakes with a variable-latency memory and honours a pipeline stall. It sits between the instruction register and the shared datapath (PC, regfile, ALU, memory port).

---
 rtl/mc_control_pkg.sv | 98 +++++++++
 rtl/mc_control_out_dec.sv | 102 ++++++++++
 rtl/mc_control_fsm.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle MIPS-lite main controller:
// opcodes, ALU operation codes, state encodings, datapath select
// encodings and the packed control word produced by the output decoder.
package mc_control_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation codes (3-bit core, zero-extended at the top level)
    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_OR    = 3'b010;
    localparam logic [2:0] ALU_OP_FUNCT = 3'b011;
    localparam logic [2:0] ALU_OP_XOR   = 3'b100;
    localparam logic [2:0] ALU_OP_AND   = 3'b101;
    localparam logic [2:0] ALU_OP_ADDI  = 3'b110;

    // Controller states, 4-bit binary
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEM_ADR = 4'd2,
        ST_MEM_RD  = 4'd3,
        ST_MEM_WB  = 4'd4,
        ST_MEM_WR  = 4'd5,
        ST_R_EXEC  = 4'd6,
        ST_R_WB    = 4'd7,
        ST_I_EXEC  = 4'd8,
        ST_I_WB    = 4'd9,
        ST_BRANCH  = 4'd10,
        ST_JUMP    = 4'd11,
        ST_TRAP    = 4'd12
    } state_t;

    // pc_src
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // reg_dst
    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    // mem_to_reg
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // alu_src_b
    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // Raw state-decoded control word, before stall / handshake gating
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       extend_op;
    } ctrl_t;

    // States whose exit into FETCH completes (retires) an instruction
    function automatic logic is_retire_state(input state_t s);
        return s inside {ST_MEM_WB, ST_MEM_WR, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP};
    endfunction

    // ALU operation for the immediate-arithmetic group
    function automatic logic [2:0] imm_alu_op(input logic [5:0] opc);
        case (opc)
            OP_ORI:  return ALU_OP_OR;
            OP_XORI: return ALU_OP_XOR;
            OP_ANDI: return ALU_OP_AND;
            OP_ADDI: return ALU_OP_ADDI;
            default: return ALU_OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_out_dec.sv
// Combinational (state, opcode) -> control-word decoder for the
// multi-cycle controller. Produces the ungated Moore control word; the
// FSM applies stall and memory-handshake qualification.
module mc_control_out_dec
    import mc_control_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opc,
    output ctrl_t      ctrl
);

    logic [2:0] i_alu_op;
    logic       i_ext;

    assign i_alu_op = imm_alu_op(opc);
    // Only ADDI is a signed immediate; logical immediates zero-extend
    assign i_ext    = (opc == OP_ADDI);

    // Per-state control word, everything inactive unless the state asks for it
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PC_SRC_ALU;
            end
            ST_DECODE: begin
                // Branch target PC+4+(imm<<2); the offset is signed
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.extend_op = 1'b1;
            end
            ST_MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.extend_op = 1'b1;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = M2R_MDR;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.alu_op     = ALU_OP_FUNCT;
            end
            ST_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = i_alu_op;
                ctrl.extend_op = i_ext;
            end
            ST_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.alu_op     = i_alu_op;
                ctrl.extend_op  = i_ext;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PC_SRC_ALUOUT;
                ctrl.extend_op     = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_SRC_JUMP;
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RA;
                ctrl.mem_to_reg = M2R_PC;
            end
            default: ;  // TRAP and unused encodings: all inactive
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller for the MIPS-lite core. Sequences
// fetch/decode/execute/memory/writeback, handshakes with a variable-latency
// memory (mem_ready) and freezes on stall.
// Handshake: a memory request (mem_read/mem_write with stable iord) stays
// asserted until mem_ready is sampled high with stall low; stall masks all
// requests and enables, so mem_ready seen during a stall is ignored.
// Optional: define MC_CONTROL_PERF_CNT_EN to add retired_cnt / stall_cnt.
module mc_control_fsm
    import mc_control_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3   // must be >= 3
`ifdef MC_CONTROL_PERF_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     op,
    input  logic                stall,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_src,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                extend_op,
    output logic                illegal_op,
    output logic [3:0]          state
`ifdef MC_CONTROL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    retired_cnt,
    output logic [CNT_W-1:0]    stall_cnt
`endif
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl;
    logic [5:0] opc;
    logic       run;
    logic       illegal_q;

    assign opc = 6'(op);
    assign run = ~stall;

    mc_control_out_dec u_out_dec (
        .state (state_q),
        .opc   (opc),
        .ctrl  (ctrl)
    );

    // Next-state: hold under stall, otherwise sequence per instruction class
    always_comb begin
        state_d = state_q;
        if (run) begin
            case (state_q)
                ST_FETCH:   if (mem_ready) state_d = ST_DECODE;
                ST_DECODE: begin
                    case (opc)
                        OP_RTYPE:                         state_d = ST_R_EXEC;
                        OP_LW, OP_SW:                     state_d = ST_MEM_ADR;
                        OP_BEQ:                           state_d = ST_BRANCH;
                        OP_JAL:                           state_d = ST_JUMP;
                        OP_ORI, OP_XORI, OP_ANDI, OP_ADDI: state_d = ST_I_EXEC;
                        default:                          state_d = ST_TRAP;
                    endcase
                end
                ST_MEM_ADR: state_d = (opc == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD:  if (mem_ready) state_d = ST_MEM_WB;
                ST_MEM_WR:  if (mem_ready) state_d = ST_FETCH;
                ST_R_EXEC:  state_d = ST_R_WB;
                ST_I_EXEC:  state_d = ST_I_WB;
                ST_MEM_WB, ST_R_WB, ST_I_WB,
                ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
                ST_TRAP:    state_d = ST_TRAP;
                default:    state_d = ST_FETCH;
            endcase
        end
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     illegal_q <= 1'b0;
        else if (state_d == ST_TRAP) illegal_q <= 1'b1;
    end

    // Enables are stall-gated; IR/PC load in FETCH also waits for mem_ready.
    // Selects and alu_op keep their state-decoded values during a stall.
    assign pc_write      = ctrl.pc_write & run & ((state_q != ST_FETCH) | mem_ready);
    assign pc_write_cond = ctrl.pc_write_cond & run;
    assign ir_write      = ctrl.ir_write & run & mem_ready;
    assign reg_write     = ctrl.reg_write & run;
    assign mem_read      = ctrl.mem_read & run;
    assign mem_write     = ctrl.mem_write & run;
    assign pc_src        = ctrl.pc_src;
    assign iord          = ctrl.iord;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ALU_OP_W'(ctrl.alu_op);
    assign extend_op     = ctrl.extend_op;
    assign illegal_op    = illegal_q;
    assign state         = state_q;

`ifdef MC_CONTROL_PERF_CNT_EN
    logic retire;
    assign retire = run && (state_d == ST_FETCH) && is_retire_state(state_q);

    // Retired-instruction counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         retired_cnt <= '0;
        else if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
    end

    // Stall-cycle counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        stall_cnt <= '0;
        else if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
    end
`endif

endmodule
